// File: rtl/regfile_alu.sv
// Execute-stage core: 32x32 register file (two async read ports, one sync write
// port) feeding a combinational ALU whose operand A is always read port 1.
module regfile_alu (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  input  logic [4:0]  writeReg,
  input  logic [31:0] writeData,
  input  logic        regWrite,
  input  logic [31:0] aluB,
  input  logic [2:0]  ALUOp,
  output logic [31:0] regData1,
  output logic [31:0] regData2,
  output logic [31:0] aluResult,
  output logic        aluZeroFlag
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;

  logic [31:0] regs [0:31];
  logic [31:0] mul_low;

  // x0 is never written, so the zero-address mux below is what makes it read 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (regWrite && (writeReg != 5'd0)) begin
      regs[writeReg] <= writeData;
    end
  end

  // No bypass: a same-cycle write is only visible after the edge.
  always_comb begin
    regData1 = (readReg1 == 5'd0) ? 32'h0 : regs[readReg1];
    regData2 = (readReg2 == 5'd0) ? 32'h0 : regs[readReg2];
  end

  assign mul_low = regData1 * aluB;

  always_comb begin
    aluResult = 32'h0;
    case (ALUOp)
      OP_ADD:  aluResult = regData1 + aluB;
      OP_SUB:  aluResult = regData1 - aluB;
      OP_MUL:  aluResult = mul_low;
      OP_AND:  aluResult = regData1 & aluB;
      OP_OR:   aluResult = regData1 | aluB;
      OP_SLL:  aluResult = regData1 << aluB[4:0];
      default: aluResult = 32'h0;
    endcase
  end

  assign aluZeroFlag = (aluResult == 32'h0);

endmodule

// File: tb/tb_regfile_alu.sv
// Directed plus light random bench for regfile_alu; expectations are queued
// in exp_q when a step is driven and popped when the output is sampled.
module tb_regfile_alu;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  readReg1 = '0;
  logic [4:0]  readReg2 = '0;
  logic [4:0]  writeReg = '0;
  logic [31:0] writeData = '0;
  logic        regWrite = 1'b0;
  logic [31:0] aluB = '0;
  logic [2:0]  ALUOp = '0;
  logic [31:0] regData1;
  logic [31:0] regData2;
  logic [31:0] aluResult;
  logic        aluZeroFlag;

  regfile_alu dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .regWrite    (regWrite),
    .aluB        (aluB),
    .ALUOp       (ALUOp),
    .regData1    (regData1),
    .regData2    (regData2),
    .aluResult   (aluResult),
    .aluZeroFlag (aluZeroFlag)
  );

  // clock / reset block
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] model [0:31];
  int vectors = 0;
  int miscompares = 0;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed=%h expected=<empty queue>", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      vectors++;
      assert (observed === expected) else begin
        miscompares++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    writeReg  = addr;
    writeData = data;
    regWrite  = 1'b1;
    tick();
    regWrite  = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] full;
    full = {32'h0, a} * {32'h0, b};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return full[31:0];
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a << b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] sweep_exp [0:7];

  initial begin
    sweep_exp[0] = 32'd10; sweep_exp[1] = 32'd4;  sweep_exp[2] = 32'd21;
    sweep_exp[3] = 32'd3;  sweep_exp[4] = 32'd7;  sweep_exp[5] = 32'd56;
    sweep_exp[6] = 32'd0;  sweep_exp[7] = 32'd0;

    tick();
    do_reset();

    // every address reads zero on both ports after reset
    for (int a = 0; a < 32; a++) begin
      readReg1 = a[4:0];
      readReg2 = 5'(31 - a);
      #1;
      push_exp(32'h0); check($sformatf("rst_rd1_x%0d", a), regData1);
      push_exp(32'h0); check($sformatf("rst_rd2_x%0d", 31 - a), regData2);
    end
    ALUOp = 3'd0; aluB = 32'h0; readReg1 = 5'd7; #1;
    push_exp(32'h0); check("rst_add_res", aluResult);
    push_exp(32'h1); check("rst_add_zero", {31'h0, aluZeroFlag});

    // operation sweep on x5=7, B=3
    wr(5'd5, 32'h7);
    wr(5'd6, 32'h3);
    readReg1 = 5'd5; readReg2 = 5'd6; aluB = 32'd3; #1;
    push_exp(32'h7); check("x5_rd1", regData1);
    push_exp(32'h3); check("x6_rd2", regData2);
    for (int op = 0; op < 8; op++) begin
      ALUOp = op[2:0]; #1;
      push_exp(sweep_exp[op]); check($sformatf("sweep_op%0d_res", op), aluResult);
      push_exp((op >= 6) ? 32'h1 : 32'h0);
      check($sformatf("sweep_op%0d_zero", op), {31'h0, aluZeroFlag});
    end

    // writes to x0 are dropped
    wr(5'd0, 32'hDEAD_BEEF);
    readReg1 = 5'd0; readReg2 = 5'd0; #1;
    push_exp(32'h0); check("x0_rd1", regData1);
    push_exp(32'h0); check("x0_rd2", regData2);

    // write-then-read timing on x1 and wraparound
    readReg1 = 5'd1; readReg2 = 5'd1;
    writeReg = 5'd1; writeData = 32'hFFFF_FFFF; regWrite = 1'b1; #1;
    push_exp(32'h0); check("x1_before_edge", regData1);
    tick();
    regWrite = 1'b0; model[1] = 32'hFFFF_FFFF;
    push_exp(32'hFFFF_FFFF); check("x1_after_edge_rd1", regData1);
    push_exp(32'hFFFF_FFFF); check("x1_after_edge_rd2", regData2);
    ALUOp = 3'd0; aluB = 32'd1; #1;
    push_exp(32'h0); check("add_wrap_res", aluResult);
    push_exp(32'h1); check("add_wrap_zero", {31'h0, aluZeroFlag});
    wr(5'd1, 32'h0);
    ALUOp = 3'd1; aluB = 32'd1; #1;
    push_exp(32'hFFFF_FFFF); check("sub_wrap_res", aluResult);
    push_exp(32'h0); check("sub_wrap_zero", {31'h0, aluZeroFlag});

    // shift amount uses B[4:0] only; MUL keeps low 32 bits
    wr(5'd2, 32'h8000_0001);
    readReg1 = 5'd2; ALUOp = 3'd5; aluB = 32'h0000_0021; #1;
    push_exp(32'h0000_0002); check("sll_mask", aluResult);
    wr(5'd4, 32'h0001_0000);
    readReg1 = 5'd4; ALUOp = 3'd2; aluB = 32'h0001_0000; #1;
    push_exp(32'h0); check("mul_trunc_res", aluResult);
    push_exp(32'h1); check("mul_trunc_zero", {31'h0, aluZeroFlag});

    // random writes and operations against the model
    for (int n = 0; n < 40; n++) begin
      wr(5'($urandom_range(0, 31)), $urandom);
      readReg1 = 5'($urandom_range(0, 31));
      readReg2 = 5'($urandom_range(0, 31));
      ALUOp    = 3'($urandom_range(0, 7));
      aluB     = ($urandom_range(0, 3) == 0) ? model[readReg2] : $urandom;
      #1;
      push_exp(model[readReg1]); check($sformatf("rnd%0d_rd1", n), regData1);
      push_exp(model[readReg2]); check($sformatf("rnd%0d_rd2", n), regData2);
      push_exp(alu_model(ALUOp, model[readReg1], aluB));
      check($sformatf("rnd%0d_res", n), aluResult);
    end

    // reset beats a simultaneous write; write lands on first non-reset edge
    readReg1 = 5'd3; readReg2 = 5'd5; ALUOp = 3'd0; aluB = 32'h0;
    writeReg = 5'd3; writeData = 32'd9; regWrite = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    push_exp(32'h0); check("rst_write_x3", regData1);
    push_exp(32'h0); check("rst_clear_x5", regData2);
    push_exp(32'h0); check("rst_add_res2", aluResult);
    push_exp(32'h1); check("rst_add_zero2", {31'h0, aluZeroFlag});
    tick();
    regWrite = 1'b0;
    push_exp(32'd9); check("post_rst_write_x3", regData1);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_queue: observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
